// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, MixColumns coefficient tables and GF(2^8) helpers
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // base[0] occupies the top nibble: base = {b0, b1, b2, b3}
    localparam logic [15:0] MC_FWD_COEFF = {4'h2, 4'h3, 4'h1, 4'h1};
    localparam logic [15:0] MC_INV_COEFF = {4'hE, 4'hB, 4'hD, 4'h9};

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] mc_coeff(input logic inv, input logic [1:0] idx);
        logic [15:0] tbl;
        tbl = inv ? MC_INV_COEFF : MC_FWD_COEFF;
        return tbl[{~idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/gf2_mult.sv
// rtl/gf2_mult.sv - combinational GF(2^8) multiply of a byte by a 4-bit coefficient
module gf2_mult
    import aes_pkg::*;
(
    input  byte_t      data,
    input  logic [3:0] coeff,
    output byte_t      prod
);

    byte_t x1;
    byte_t x2;
    byte_t x3;

    always_comb begin
        x1   = xtime(data);
        x2   = xtime(x1);
        x3   = xtime(x2);
        prod = (coeff[0] ? data : 8'h00) ^
               (coeff[1] ? x1   : 8'h00) ^
               (coeff[2] ? x2   : 8'h00) ^
               (coeff[3] ? x3   : 8'h00);
    end

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential (Inv)MixColumns over one shared gf2_mult, 64 cycles per block
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int CW = $clog2(NUM_COLS * NUM_COLS * 4);

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  st_reg;
    logic          inv_reg;
    logic [CW-1:0] cnt;
    byte_t         acc;
    byte_t         data_byte;
    byte_t         prod;
    logic [3:0]    coeff;
    logic [1:0]    col;
    logic [1:0]    row;
    logic [1:0]    k;

    assign {col, row, k} = cnt;

    // byte n lives at bits [127-8n -: 8], i.e. base bit 8*(15-n) = {~n, 3'b000}
    assign data_byte = st_reg[{~{col, k}, 3'b000} +: 8];
    assign coeff     = mc_coeff(inv_reg, k - row);

    gf2_mult u_gf2_mult (
        .data  (data_byte),
        .coeff (coeff),
        .prod  (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '1) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result bytes land directly in out_state; st_reg stays untouched during CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_reg    <= '0;
            inv_reg   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            out_state <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                st_reg  <= in_state;
                inv_reg <= in_inv;
                cnt     <= '0;
                acc     <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                if (k == 2'd3) begin
                    out_state[{~{col, row}, 3'b000} +: 8] <= acc ^ prod;
                    acc <= '0;
                end else begin
                    acc <= acc ^ prod;
                end
            end
        end
    end

endmodule
